// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// Module   : div_pkg
// Purpose  : Shared FSM state encoding and default operand widths for divider_ctrl.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    localparam int c_DEVIDENT_LENGTH = 10;
    localparam int c_DIVISOR_LENGTH  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/divider_ctrl_div.sv
//------------------------------------------------------------------------------
// Module   : divider_ctrl_div
// Purpose  : Combinational unsigned restoring divider (quotient and remainder).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider_ctrl_div
    import div_pkg::*;
#(
    parameter int DEVIDENT_LENGTH = c_DEVIDENT_LENGTH,
    parameter int DIVISOR_LENGTH  = c_DIVISOR_LENGTH
) (
    input  logic [DEVIDENT_LENGTH-1:0] i_dividend,
    input  logic [DIVISOR_LENGTH-1:0]  i_divisor,
    output logic [DEVIDENT_LENGTH-1:0] o_quotient,
    output logic [DIVISOR_LENGTH-1:0]  o_remainder
);

    // One guard bit above the divisor width holds the shifted partial remainder.
    logic [DIVISOR_LENGTH:0]    w_part;
    logic [DEVIDENT_LENGTH-1:0] w_quot;

    always_comb begin
        w_part = '0;
        w_quot = '0;
        for (int i = DEVIDENT_LENGTH - 1; i >= 0; i--) begin
            w_part = {w_part[DIVISOR_LENGTH-1:0], i_dividend[i]};
            if (w_part >= {1'b0, i_divisor}) begin
                w_part    = w_part - {1'b0, i_divisor};
                w_quot[i] = 1'b1;
            end
        end
    end

    assign o_quotient  = w_quot;
    assign o_remainder = w_part[DIVISOR_LENGTH-1:0];

endmodule

`default_nettype wire

// File: rtl/divider_ctrl.sv
//------------------------------------------------------------------------------
// Module   : divider_ctrl
// Purpose  : Valid/ready wrapper around a combinational divider (IDLE/CALC/HOLD).
//            Define DIV_ZERO_CHECK_EN to flag and override divide-by-zero results.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider_ctrl
    import div_pkg::*;
#(
    parameter int DEVIDENT_LENGTH = c_DEVIDENT_LENGTH,
    parameter int DIVISOR_LENGTH  = c_DIVISOR_LENGTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [DEVIDENT_LENGTH-1:0] OperA,
    input  logic [DIVISOR_LENGTH-1:0]  OperD,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [DEVIDENT_LENGTH-1:0] Quotient,
    output logic [DIVISOR_LENGTH-1:0]  Remainder,
    output logic                       Div_By_Zero
);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DEVIDENT_LENGTH-1:0] r_opa;
    logic [DIVISOR_LENGTH-1:0]  r_opd;
    logic [DEVIDENT_LENGTH-1:0] r_quot;
    logic [DIVISOR_LENGTH-1:0]  r_rem;
    logic [DEVIDENT_LENGTH-1:0] w_div_q;
    logic [DIVISOR_LENGTH-1:0]  w_div_r;
    logic [DEVIDENT_LENGTH-1:0] w_quot_sel;
    logic [DIVISOR_LENGTH-1:0]  w_rem_sel;

    divider_ctrl_div #(
        .DEVIDENT_LENGTH (DEVIDENT_LENGTH),
        .DIVISOR_LENGTH  (DIVISOR_LENGTH)
    ) u_div (
        .i_dividend  (r_opa),
        .i_divisor   (r_opd),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        In_Ready    = 1'b0;
        Out_Valid   = 1'b0;
        case (r_state)
            IDLE: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                Out_Valid = 1'b1;
                if (Out_Ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef DIV_ZERO_CHECK_EN
    logic w_dbz;
    logic r_dbz;

    // A zero divisor bypasses the divider: saturated quotient, low dividend bits as remainder.
    assign w_dbz      = (r_opd == '0);
    assign w_quot_sel = w_dbz ? '1 : w_div_q;
    assign w_rem_sel  = w_dbz ? r_opa[DIVISOR_LENGTH-1:0] : w_div_r;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_dbz <= 1'b0;
        end else if (r_state == CALC) begin
            r_dbz <= w_dbz;
        end
    end

    assign Div_By_Zero = r_dbz;
`else
    assign w_quot_sel  = w_div_q;
    assign w_rem_sel   = w_div_r;
    assign Div_By_Zero = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_opa  <= '0;
            r_opd  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
        end else begin
            if (r_state == IDLE && In_Valid) begin
                r_opa <= OperA;
                r_opd <= OperD;
            end
            if (r_state == CALC) begin
                r_quot <= w_quot_sel;
                r_rem  <= w_rem_sel;
            end
        end
    end

    assign Quotient  = r_quot;
    assign Remainder = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_divider_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_divider_ctrl
// Purpose  : Self-checking bench for divider_ctrl; expectations follow DIV_ZERO_CHECK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_divider_ctrl;

    localparam int AW = 10;
    localparam int DW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [AW-1:0] OperA = '0;
    logic [DW-1:0] OperD = '0;
    logic          Out_Valid;
    logic          Out_Ready = 1'b0;
    logic [AW-1:0] Quotient;
    logic [DW-1:0] Remainder;
    logic          Div_By_Zero;

    int n_cmp = 0;
    int n_err = 0;

    divider_ctrl #(
        .DEVIDENT_LENGTH (AW),
        .DIVISOR_LENGTH  (DW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .OperA       (OperA),
        .OperD       (OperD),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_By_Zero (Div_By_Zero)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        n_cmp++;
        if (In_Ready && Out_Valid) begin
            n_err++;
            $display("FAIL handshake_exclusive: In_Ready=%0b Out_Valid=%0b required not both 1", In_Ready, Out_Valid);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: plain arithmetic; chk_qr=0 where the result value is left undefined.
    task automatic ref_div(input int a, input int d, output int q, output int r,
                           output bit z, output bit chk_qr);
        chk_qr = 1'b1;
        if (d == 0) begin
`ifdef DIV_ZERO_CHECK_EN
            q = (1 << AW) - 1;
            r = a % (1 << DW);
            z = 1'b1;
`else
            q = 0;
            r = 0;
            z = 1'b0;
            chk_qr = 1'b0;
`endif
        end else begin
            q = a / d;
            r = a % d;
            z = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || Quotient !== '0 || Remainder !== '0 || Div_By_Zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%0b vld=%0b q=%0d r=%0d z=%0b required 1 0 0 0 0",
                     In_Ready, Out_Valid, Quotient, Remainder, Div_By_Zero);
        end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        OperA = 10'd21; OperD = 5'd7; In_Valid = 1'b1; Out_Ready = 1'b1;
        n_cmp++;
        if (In_Ready !== 1'b1) begin
            n_err++; $display("FAIL basic_idle_ready: got %0b required 1", In_Ready);
        end
        tick();
        In_Valid = 1'b0;
        n_cmp++;
        if (In_Ready !== 1'b0 || Out_Valid !== 1'b0) begin
            n_err++; $display("FAIL basic_calc: rdy=%0b vld=%0b required 0 0", In_Ready, Out_Valid);
        end
        tick();
        n_cmp++;
        if (Out_Valid !== 1'b1 || Quotient !== 10'd3 || Remainder !== 5'd0) begin
            n_err++; $display("FAIL basic_result: vld=%0b q=%0d r=%0d required 1 3 0", Out_Valid, Quotient, Remainder);
        end
        tick();
        n_cmp++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            n_err++; $display("FAIL basic_release: vld=%0b rdy=%0b required 0 1", Out_Valid, In_Ready);
        end
    endtask

    task automatic test_stall();
        OperA = 10'd25; OperD = 5'd7; In_Valid = 1'b1; Out_Ready = 1'b0;
        tick();
        In_Valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || Quotient !== 10'd3 || Remainder !== 5'd4) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: vld=%0b rdy=%0b q=%0d r=%0d required 1 0 3 4",
                         i, Out_Valid, In_Ready, Quotient, Remainder);
            end
            tick();
        end
        Out_Ready = 1'b1;
        tick();
        n_cmp++;
        if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release: vld=%0b rdy=%0b required 0 1", Out_Valid, In_Ready);
        end
    endtask

    task automatic test_max();
        OperA = 10'd1023; OperD = 5'd31; In_Valid = 1'b1; Out_Ready = 1'b1;
        tick();
        In_Valid = 1'b0;
        tick();
        n_cmp++;
        if (Out_Valid !== 1'b1 || Quotient !== 10'd33 || Remainder !== 5'd0) begin
            n_err++; $display("FAIL max_operands: vld=%0b q=%0d r=%0d required 1 33 0", Out_Valid, Quotient, Remainder);
        end
        tick();
    endtask

    task automatic test_div_zero();
        OperA = 10'd100; OperD = 5'd0; In_Valid = 1'b1; Out_Ready = 1'b1;
        tick();
        In_Valid = 1'b0;
        tick();
`ifdef DIV_ZERO_CHECK_EN
        n_cmp++;
        if (Out_Valid !== 1'b1 || Quotient !== 10'd1023 || Remainder !== 5'd4 || Div_By_Zero !== 1'b1) begin
            n_err++;
            $display("FAIL div_zero: vld=%0b q=%0d r=%0d z=%0b required 1 1023 4 1",
                     Out_Valid, Quotient, Remainder, Div_By_Zero);
        end
`else
        n_cmp++;
        if (Out_Valid !== 1'b1 || Div_By_Zero !== 1'b0) begin
            n_err++; $display("FAIL div_zero_flag: vld=%0b z=%0b required 1 0", Out_Valid, Div_By_Zero);
        end
`endif
        tick();
    endtask

    task automatic test_reset_in_calc();
        int pulses;
        OperA = 10'd500; OperD = 5'd9; In_Valid = 1'b1; Out_Ready = 1'b1;
        tick();
        In_Valid = 1'b0;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        n_cmp++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || Quotient !== '0 || Remainder !== '0 || Div_By_Zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_calc: rdy=%0b vld=%0b q=%0d r=%0d z=%0b required 1 0 0 0 0",
                     In_Ready, Out_Valid, Quotient, Remainder, Div_By_Zero);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Out_Valid === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++; $display("FAIL reset_no_pulse: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_ignore_inputs();
        OperA = 10'd999; OperD = 5'd10; In_Valid = 1'b1; Out_Ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            OperA = AW'($urandom);
            OperD = DW'($urandom_range(1, 31));
            tick();
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        n_cmp++;
        if (Out_Valid !== 1'b1 || Quotient !== 10'd99 || Remainder !== 5'd9) begin
            n_err++; $display("FAIL ignore_inputs: vld=%0b q=%0d r=%0d required 1 99 9", Out_Valid, Quotient, Remainder);
        end
        tick();
    endtask

    task automatic test_random();
        int a, d, q, r, wait_cyc;
        bit z, chk;
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(0, 1023));
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            ref_div(a, d, q, r, z, chk);
            OperA = AW'(a); OperD = DW'(d); In_Valid = 1'b1; Out_Ready = 1'b0;
            tick();
            In_Valid = 1'b0;
            wait_cyc = 0;
            while (Out_Valid !== 1'b1 && wait_cyc < 4) begin
                In_Valid = 1'($urandom);
                OperA = AW'($urandom);
                tick();
                wait_cyc++;
            end
            In_Valid = 1'b0;
            n_cmp++;
            if (Out_Valid !== 1'b1) begin
                n_err++; $display("FAIL random_timeout[%0d]: Out_Valid=%0b required 1", n, Out_Valid);
            end
            repeat ($urandom_range(0, 3)) tick();
            n_cmp++;
            if (Div_By_Zero !== z || (chk && (Quotient !== AW'(q) || Remainder !== DW'(r)))) begin
                n_err++;
                $display("FAIL random[%0d] %0d/%0d: q=%0d r=%0d z=%0b required %0d %0d %0b",
                         n, a, d, Quotient, Remainder, Div_By_Zero, q, r, z);
            end
            Out_Ready = 1'b1;
            tick();
        end
        Out_Ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int a, d, q, r;
        bit z, chk;
        In_Valid = 1'b1; Out_Ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            a = int'($urandom_range(0, 1023));
            d = int'($urandom_range(1, 31));
            ref_div(a, d, q, r, z, chk);
            OperA = AW'(a); OperD = DW'(d);
            n_cmp++;
            if (In_Ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready[%0d]: got %0b required 1", n, In_Ready);
            end
            tick();
            OperA = AW'($urandom); OperD = DW'($urandom);
            tick();
            n_cmp++;
            if (Out_Valid !== 1'b1 || Quotient !== AW'(q) || Remainder !== DW'(r)) begin
                n_err++;
                $display("FAIL b2b_result[%0d] %0d/%0d: vld=%0b q=%0d r=%0d required 1 %0d %0d",
                         n, a, d, Out_Valid, Quotient, Remainder, q, r);
            end
            tick();
        end
        In_Valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_max();
        test_div_zero();
        test_reset_in_calc();
        test_ignore_inputs();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
